// File: rtl/core_csr_access.sv
// ---------------------------------------------------------------------------
// core_csr_access
//
// Executes one RISC-V Zicsr instruction (CSRRW/S/C and their immediate forms)
// against an external CSR file with a combinational read port and a one-cycle
// write strobe, then hands the old CSR value back for register writeback.
//
// Sequence: IDLE -> READ -> (WRITE) -> FIN -> IDLE
//   cycle 0 : IDLE, START sampled, operands latched
//   cycle 1 : READ, CSR_ADDR driven, CSR_RDATA captured as the old value
//   cycle 2 : WRITE (only when a write is required), CSR_WE pulse
//   cycle 2/3 : FIN, DONE pulse, RD_* writeback, ILLEGAL status
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   START               request; only looked at in IDLE
//   FUNCT3              instruction funct3 (bit 2 selects the zimm forms)
//   CSR_NUM             target CSR address
//   RS1_NUM             rs1 index, or zimm for the immediate forms
//   RS1_DATA            rs1 register value
//   RD_NUM              destination register index
//   CSR_ADDR            CSR file address (latched CSR_NUM while busy, else 0)
//   CSR_WDATA, CSR_WE   CSR file write data / strobe (non-zero only in WRITE)
//   CSR_RDATA           CSR file read data, combinational from CSR_ADDR
//   BUSY                high in every state except IDLE
//   DONE                one-cycle completion pulse (FIN)
//   ILLEGAL             valid with DONE only; 0 otherwise
//   RD_WE, RD_ADDR,
//   RD_DATA             register writeback, driven only in FIN
//
// Configuration
//   CORE_CSR_ACCESS_RO_CHECK_EN : when defined, a required write to a CSR in
//   the read-only space (CSR_NUM[11:10] == 2'b11) is reported as illegal.
//   Suppressed writes (set/clear with rs1/zimm == 0) to that space stay legal.
// ---------------------------------------------------------------------------
module core_csr_access (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [2:0]  FUNCT3,
    input  logic [11:0] CSR_NUM,
    input  logic [4:0]  RS1_NUM,
    input  logic [31:0] RS1_DATA,
    input  logic [4:0]  RD_NUM,
    output logic [11:0] CSR_ADDR,
    output logic [31:0] CSR_WDATA,
    output logic        CSR_WE,
    input  logic [31:0] CSR_RDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        ILLEGAL,
    output logic        RD_WE,
    output logic [4:0]  RD_ADDR,
    output logic [31:0] RD_DATA
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [2:0]  r_funct3;
    logic [11:0] r_csr_num;
    logic [4:0]  r_rs1_num;
    logic [31:0] r_rs1_data;
    logic [4:0]  r_rd_num;
    logic [31:0] r_old;
    logic        r_illegal;

    logic [1:0]  w_op;
    logic [31:0] w_src;
    logic [31:0] w_new;
    logic        w_wr_req;
    logic        w_ro_fault;
    logic        w_illegal;

    // funct3[1:0]: 01 write, 10 set, 11 clear, 00 reserved (000 and 100)
    assign w_op  = r_funct3[1:0];
    assign w_src = r_funct3[2] ? {27'd0, r_rs1_num} : r_rs1_data;

    // Set/clear with a zero rs1 index (or zimm) is a pure read.
    assign w_wr_req = (w_op == 2'b01) || (r_rs1_num != 5'd0);

`ifdef CORE_CSR_ACCESS_RO_CHECK_EN
    assign w_ro_fault = w_wr_req && (r_csr_num[11:10] == 2'b11);
`else
    assign w_ro_fault = 1'b0;
`endif

    assign w_illegal = (w_op == 2'b00) || w_ro_fault;

    always_comb begin
        w_new = 32'd0;
        case (w_op)
            2'b01:   w_new = w_src;
            2'b10:   w_new = r_old | w_src;
            2'b11:   w_new = r_old & ~w_src;
            default: w_new = 32'd0;
        endcase
    end

    // State register and operand latches
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_funct3   <= 3'd0;
            r_csr_num  <= 12'd0;
            r_rs1_num  <= 5'd0;
            r_rs1_data <= 32'd0;
            r_rd_num   <= 5'd0;
            r_old      <= 32'd0;
            r_illegal  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE && START) begin
                r_funct3   <= FUNCT3;
                r_csr_num  <= CSR_NUM;
                r_rs1_num  <= RS1_NUM;
                r_rs1_data <= RS1_DATA;
                r_rd_num   <= RD_NUM;
                r_illegal  <= 1'b0;
            end
            if (r_state == S_READ) begin
                r_old     <= CSR_RDATA;
                r_illegal <= w_illegal;
            end
        end
    end

    // Next state and outputs; everything defaults to 0 so that the strobes
    // and data buses are quiet outside their owning state.
    always_comb begin
        w_next_state = r_state;
        CSR_ADDR     = 12'd0;
        CSR_WDATA    = 32'd0;
        CSR_WE       = 1'b0;
        BUSY         = 1'b0;
        DONE         = 1'b0;
        ILLEGAL      = 1'b0;
        RD_WE        = 1'b0;
        RD_ADDR      = 5'd0;
        RD_DATA      = 32'd0;

        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_next_state = S_READ;
                end
            end
            S_READ: begin
                BUSY     = 1'b1;
                CSR_ADDR = r_csr_num;
                if (w_illegal || !w_wr_req) begin
                    w_next_state = S_FIN;
                end else begin
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                BUSY         = 1'b1;
                CSR_ADDR     = r_csr_num;
                CSR_WE       = 1'b1;
                CSR_WDATA    = w_new;
                w_next_state = S_FIN;
            end
            S_FIN: begin
                BUSY         = 1'b1;
                CSR_ADDR     = r_csr_num;
                DONE         = 1'b1;
                ILLEGAL      = r_illegal;
                RD_ADDR      = r_rd_num;
                RD_DATA      = r_old;
                RD_WE        = (r_rd_num != 5'd0) && !r_illegal;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_core_csr_access.sv
// ---------------------------------------------------------------------------
// tb_core_csr_access
//
// Directed bench for core_csr_access. A behavioural CSR file (4096 x 32)
// answers CSR_ADDR combinationally and takes CSR_WE writes on the clock edge;
// a side preload port lets tests seed CSR contents while the DUT is idle.
// Cycle numbering follows the design: cycle 0 is the cycle START is high in
// IDLE. Outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_core_csr_access;

  logic        CLK;
  logic        RST;
  logic        START;
  logic [2:0]  FUNCT3;
  logic [11:0] CSR_NUM;
  logic [4:0]  RS1_NUM;
  logic [31:0] RS1_DATA;
  logic [4:0]  RD_NUM;
  logic [11:0] CSR_ADDR;
  logic [31:0] CSR_WDATA;
  logic        CSR_WE;
  logic [31:0] CSR_RDATA;
  logic        BUSY;
  logic        DONE;
  logic        ILLEGAL;
  logic        RD_WE;
  logic [4:0]  RD_ADDR;
  logic [31:0] RD_DATA;

  int tests_run;
  int tests_failed;

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- CSR file model ----------------
  logic [31:0] csr_mem [0:4095];
  logic        pre_we;
  logic [11:0] pre_addr;
  logic [31:0] pre_data;

  assign CSR_RDATA = csr_mem[CSR_ADDR];

  always @(posedge CLK) begin
    if (pre_we) csr_mem[pre_addr] <= pre_data;
    else if (CSR_WE) csr_mem[CSR_ADDR] <= CSR_WDATA;
  end

  core_csr_access dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .FUNCT3    (FUNCT3),
    .CSR_NUM   (CSR_NUM),
    .RS1_NUM   (RS1_NUM),
    .RS1_DATA  (RS1_DATA),
    .RD_NUM    (RD_NUM),
    .CSR_ADDR  (CSR_ADDR),
    .CSR_WDATA (CSR_WDATA),
    .CSR_WE    (CSR_WE),
    .CSR_RDATA (CSR_RDATA),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ILLEGAL   (ILLEGAL),
    .RD_WE     (RD_WE),
    .RD_ADDR   (RD_ADDR),
    .RD_DATA   (RD_DATA)
  );

  // ---------------- observation of one operation ----------------
  int          obs_we_cycle;
  int          obs_we_count;
  logic [31:0] obs_wdata;
  int          obs_done_cycle;
  logic        obs_ill;
  logic        obs_rd_we;
  logic [4:0]  obs_rd_addr;
  logic [31:0] obs_rd_data;
  logic        obs_c0_busy;
  bit          obs_side_ok;
  bit          obs_busy_ok;

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [11:0] addr, input logic [31:0] data);
    @(posedge CLK); #1;
    pre_we = 1'b1; pre_addr = addr; pre_data = data;
    @(posedge CLK); #1;
    pre_we = 1'b0;
  endtask

  // Issues one instruction and records what the DUT does, for up to 8 cycles.
  // With hold=1, START stays high through cycle 1 with unrelated operands,
  // which the DUT must ignore while busy.
  task automatic run_op(input logic [2:0] f3, input logic [11:0] csr,
                        input logic [4:0] rs1n, input logic [31:0] rs1d,
                        input logic [4:0] rd, input bit hold);
    obs_we_cycle = -1; obs_we_count = 0; obs_wdata = '0;
    obs_done_cycle = -1; obs_ill = 1'b0; obs_rd_we = 1'b0;
    obs_rd_addr = '0; obs_rd_data = '0; obs_side_ok = 1; obs_busy_ok = 1;
    @(posedge CLK); #1;
    START = 1'b1; FUNCT3 = f3; CSR_NUM = csr; RS1_NUM = rs1n;
    RS1_DATA = rs1d; RD_NUM = rd;
    obs_c0_busy = BUSY;
    for (int c = 1; c <= 8; c++) begin
      @(posedge CLK); #1;
      if (c == 1) begin
        if (hold) begin
          FUNCT3 = 3'b001; CSR_NUM = 12'h7C0; RS1_NUM = 5'd9;
          RS1_DATA = 32'hDEADBEEF; RD_NUM = 5'd1;
        end else begin
          START = 1'b0;
        end
      end
      if (c == 2) START = 1'b0;
      if (BUSY !== 1'b1) obs_busy_ok = 0;
      if (CSR_ADDR !== csr) obs_side_ok = 0;
      if (CSR_WE === 1'b1) begin
        obs_we_count++;
        if (obs_we_cycle < 0) obs_we_cycle = c;
        obs_wdata = CSR_WDATA;
      end else if (CSR_WE !== 1'b0 || CSR_WDATA !== 32'd0) begin
        obs_side_ok = 0;
      end
      if (DONE === 1'b1) begin
        obs_done_cycle = c; obs_ill = ILLEGAL; obs_rd_we = RD_WE;
        obs_rd_addr = RD_ADDR; obs_rd_data = RD_DATA;
        break;
      end else if (ILLEGAL !== 1'b0 || RD_WE !== 1'b0 || RD_DATA !== 32'd0) begin
        obs_side_ok = 0;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    tests_run++;
    if (BUSY !== 0 || DONE !== 0 || ILLEGAL !== 0 || CSR_WE !== 0 || RD_WE !== 0) begin
      tests_failed++;
      $display("FAIL reset_flags: busy=%b done=%b ill=%b we=%b rdwe=%b want all 0",
               BUSY, DONE, ILLEGAL, CSR_WE, RD_WE);
    end
    tests_run++;
    if (CSR_ADDR !== 0 || CSR_WDATA !== 0 || RD_ADDR !== 0 || RD_DATA !== 0) begin
      tests_failed++;
      $display("FAIL reset_buses: addr=%h wdata=%h rdaddr=%h rddata=%h want 0",
               CSR_ADDR, CSR_WDATA, RD_ADDR, RD_DATA);
    end
    RST = 1'b0;
  endtask

  task automatic test_csrrw;
    preload(12'h305, 32'h0000_0010);
    run_op(3'b001, 12'h305, 5'd7, 32'h8000_0000, 5'd5, 0);
    tests_run++;
    if (obs_we_cycle !== 2 || obs_we_count !== 1 || obs_wdata !== 32'h8000_0000) begin
      tests_failed++;
      $display("FAIL rw_write: cycle=%0d count=%0d wdata=%h want 2/1/80000000",
               obs_we_cycle, obs_we_count, obs_wdata);
    end
    tests_run++;
    if (obs_done_cycle !== 3 || obs_ill !== 0) begin
      tests_failed++;
      $display("FAIL rw_done: cycle=%0d ill=%b want 3/0", obs_done_cycle, obs_ill);
    end
    tests_run++;
    if (obs_rd_we !== 1 || obs_rd_addr !== 5'd5 || obs_rd_data !== 32'h10) begin
      tests_failed++;
      $display("FAIL rw_rd: we=%b addr=%0d data=%h want 1/5/00000010",
               obs_rd_we, obs_rd_addr, obs_rd_data);
    end
    tests_run++;
    if (obs_side_ok !== 1 || obs_busy_ok !== 1 || obs_c0_busy !== 0) begin
      tests_failed++;
      $display("FAIL rw_quiet: side=%0d busy=%0d c0busy=%b want 1/1/0",
               obs_side_ok, obs_busy_ok, obs_c0_busy);
    end
    tests_run++;
    if (csr_mem[12'h305] !== 32'h8000_0000) begin
      tests_failed++;
      $display("FAIL rw_mem: got %h want 80000000", csr_mem[12'h305]);
    end
  endtask

  task automatic test_csrrs_nowrite;
    preload(12'h300, 32'h0000_0008);
    run_op(3'b010, 12'h300, 5'd0, 32'hFFFF_FFFF, 5'd3, 0);
    tests_run++;
    if (obs_we_count !== 0 || obs_done_cycle !== 2) begin
      tests_failed++;
      $display("FAIL rs_nowrite: we_count=%0d done=%0d want 0/2", obs_we_count, obs_done_cycle);
    end
    tests_run++;
    if (obs_rd_we !== 1 || obs_rd_addr !== 5'd3 || obs_rd_data !== 32'h8 || obs_ill !== 0) begin
      tests_failed++;
      $display("FAIL rs_rd: we=%b addr=%0d data=%h ill=%b want 1/3/00000008/0",
               obs_rd_we, obs_rd_addr, obs_rd_data, obs_ill);
    end
  endtask

  task automatic test_csrrci;
    preload(12'h304, 32'h0000_0888);
    run_op(3'b111, 12'h304, 5'd8, 32'hFFFF_FFFF, 5'd0, 0);
    tests_run++;
    if (obs_we_cycle !== 2 || obs_wdata !== 32'h880 || obs_done_cycle !== 3) begin
      tests_failed++;
      $display("FAIL rci_write: cycle=%0d wdata=%h done=%0d want 2/00000880/3",
               obs_we_cycle, obs_wdata, obs_done_cycle);
    end
    tests_run++;
    if (obs_rd_we !== 0 || obs_rd_data !== 32'h888) begin
      tests_failed++;
      $display("FAIL rci_rd: we=%b data=%h want 0/00000888", obs_rd_we, obs_rd_data);
    end
  endtask

  task automatic test_illegal;
    logic [2:0] bad_f3 [2];
    bad_f3[0] = 3'b100;
    bad_f3[1] = 3'b000;
    preload(12'h340, 32'h0000_00AA);
    for (int i = 0; i < 2; i++) begin
      run_op(bad_f3[i], 12'h340, 5'd3, 32'h1234_5678, 5'd4, 0);
      tests_run++;
      if (obs_done_cycle !== 2 || obs_ill !== 1 || obs_we_count !== 0 || obs_rd_we !== 0) begin
        tests_failed++;
        $display("FAIL illegal_f3_%b: done=%0d ill=%b we_count=%0d rdwe=%b want 2/1/0/0",
                 bad_f3[i], obs_done_cycle, obs_ill, obs_we_count, obs_rd_we);
      end
    end
    tests_run++;
    if (csr_mem[12'h340] !== 32'hAA || obs_side_ok !== 1) begin
      tests_failed++;
      $display("FAIL illegal_mem: mem=%h side=%0d want 000000aa/1", csr_mem[12'h340], obs_side_ok);
    end
  endtask

  task automatic test_ro_space;
    preload(12'hF14, 32'h0000_0000);
    // Suppressed set to the read-only space is legal in every build.
    run_op(3'b010, 12'hF14, 5'd0, 32'h0000_00FF, 5'd6, 0);
    tests_run++;
    if (obs_ill !== 0 || obs_done_cycle !== 2 || obs_rd_we !== 1 || obs_rd_data !== 32'd0) begin
      tests_failed++;
      $display("FAIL ro_rs_read: ill=%b done=%0d rdwe=%b data=%h want 0/2/1/00000000",
               obs_ill, obs_done_cycle, obs_rd_we, obs_rd_data);
    end
    run_op(3'b001, 12'hF14, 5'd2, 32'h0000_1234, 5'd6, 0);
`ifdef CORE_CSR_ACCESS_RO_CHECK_EN
    tests_run++;
    if (obs_ill !== 1 || obs_we_count !== 0 || obs_rd_we !== 0 || obs_done_cycle !== 2) begin
      tests_failed++;
      $display("FAIL ro_rw: ill=%b we_count=%0d rdwe=%b done=%0d want 1/0/0/2",
               obs_ill, obs_we_count, obs_rd_we, obs_done_cycle);
    end
`else
    tests_run++;
    if (obs_ill !== 0 || obs_we_count !== 1 || obs_wdata !== 32'h1234 || obs_done_cycle !== 3) begin
      tests_failed++;
      $display("FAIL ro_rw: ill=%b we_count=%0d wdata=%h done=%0d want 0/1/00001234/3",
               obs_ill, obs_we_count, obs_wdata, obs_done_cycle);
    end
`endif
  endtask

  task automatic test_back_to_back;
    preload(12'h340, 32'h0000_00F0);
    preload(12'h341, 32'h0000_00FF);
    run_op(3'b110, 12'h340, 5'd5, 32'h0, 5'd7, 0);
    tests_run++;
    if (obs_wdata !== 32'hF5 || obs_done_cycle !== 3 || obs_rd_data !== 32'hF0 || obs_rd_addr !== 5'd7) begin
      tests_failed++;
      $display("FAIL b2b_rsi: wdata=%h done=%0d rd=%h addr=%0d want 000000f5/3/000000f0/7",
               obs_wdata, obs_done_cycle, obs_rd_data, obs_rd_addr);
    end
    run_op(3'b011, 12'h341, 5'd2, 32'h0000_000F, 5'd8, 0);
    tests_run++;
    if (obs_c0_busy !== 0 || obs_wdata !== 32'hF0 || obs_done_cycle !== 3 || obs_rd_data !== 32'hFF) begin
      tests_failed++;
      $display("FAIL b2b_rc: c0busy=%b wdata=%h done=%0d rd=%h want 0/000000f0/3/000000ff",
               obs_c0_busy, obs_wdata, obs_done_cycle, obs_rd_data);
    end
    // CSRRWI with zimm 0 still writes.
    run_op(3'b101, 12'h340, 5'd0, 32'hFFFF_FFFF, 5'd9, 0);
    tests_run++;
    if (obs_we_cycle !== 2 || obs_wdata !== 32'd0 || obs_rd_data !== 32'hF5 || obs_done_cycle !== 3) begin
      tests_failed++;
      $display("FAIL b2b_rwi0: cycle=%0d wdata=%h rd=%h done=%0d want 2/00000000/000000f5/3",
               obs_we_cycle, obs_wdata, obs_rd_data, obs_done_cycle);
    end
  endtask

  task automatic test_busy_ignore;
    preload(12'h342, 32'h0000_0003);
    run_op(3'b010, 12'h342, 5'd4, 32'h0000_0010, 5'd10, 1);
    tests_run++;
    if (obs_wdata !== 32'h13 || obs_rd_addr !== 5'd10 || obs_rd_data !== 32'h3 || obs_side_ok !== 1) begin
      tests_failed++;
      $display("FAIL busy_ignore: wdata=%h addr=%0d rd=%h side=%0d want 00000013/10/00000003/1",
               obs_wdata, obs_rd_addr, obs_rd_data, obs_side_ok);
    end
    @(posedge CLK); #1;
    tests_run++;
    if (BUSY !== 0 || csr_mem[12'h7C0] === 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL busy_ignore_idle: busy=%b want 0", BUSY);
    end
  endtask

  task automatic test_reset_mid;
    preload(12'h305, 32'h0000_0011);
    @(posedge CLK); #1;
    START = 1'b1; FUNCT3 = 3'b001; CSR_NUM = 12'h305; RS1_NUM = 5'd1;
    RS1_DATA = 32'h0000_5555; RD_NUM = 5'd2;
    @(posedge CLK); #1;           // cycle 1: READ
    tests_run++;
    if (BUSY !== 1 || CSR_ADDR !== 12'h305) begin
      tests_failed++;
      $display("FAIL rstmid_read: busy=%b addr=%h want 1/305", BUSY, CSR_ADDR);
    end
    RST = 1'b1;
    @(posedge CLK); #1;           // cycle 2: would have been WRITE
    RST = 1'b0; START = 1'b0;
    tests_run++;
    if (BUSY !== 0 || CSR_WE !== 0 || CSR_ADDR !== 0 || DONE !== 0 || RD_WE !== 0) begin
      tests_failed++;
      $display("FAIL rstmid_idle: busy=%b we=%b addr=%h done=%b rdwe=%b want 0/0/000/0/0",
               BUSY, CSR_WE, CSR_ADDR, DONE, RD_WE);
    end
    @(posedge CLK); #1;
    tests_run++;
    if (CSR_WE !== 0 || BUSY !== 0 || csr_mem[12'h305] !== 32'h11) begin
      tests_failed++;
      $display("FAIL rstmid_after: we=%b busy=%b mem=%h want 0/0/00000011",
               CSR_WE, BUSY, csr_mem[12'h305]);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    tests_run = 0; tests_failed = 0;
    RST = 1'b1; START = 1'b0; FUNCT3 = '0; CSR_NUM = '0; RS1_NUM = '0;
    RS1_DATA = '0; RD_NUM = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    test_reset();
    test_csrrw();
    test_csrrs_nowrite();
    test_csrrci();
    test_illegal();
    test_ro_space();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/core_csr_access.md
CORE_CSR_ACCESS -- requirements
Module: core_csr_access

Interface
REQ-001 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port RST, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port START, input, 1, request to execute one Zicsr instruction; sampled only in IDLE.
REQ-004 SHALL have port FUNCT3, input, 3, instruction funct3: 001 CSRRW, 010 CSRRS, 011 CSRRC, 101 CSRRWI, 110 CSRRSI, 111 CSRRCI.
REQ-005 SHALL have port CSR_NUM, input, 12, target CSR address.
REQ-006 SHALL have port RS1_NUM, input, 5, rs1 field, or zimm for the I-forms.
REQ-007 SHALL have port RS1_DATA, input, 32, rs1 register value.
REQ-008 SHALL have port RD_NUM, input, 5, destination register index.
REQ-009 SHALL have port CSR_ADDR, output, 12, CSR file address.
REQ-010 SHALL have port CSR_WDATA, output, 32, CSR file write data.
REQ-011 SHALL have port CSR_WE, output, 1, CSR file write strobe.
REQ-012 SHALL have port CSR_RDATA, input, 32, CSR file read data, combinational from CSR_ADDR.
REQ-013 SHALL have ports BUSY, DONE, ILLEGAL, RD_WE (each output, 1) and RD_ADDR (output, 5), RD_DATA (output, 32), for pipeline status and register writeback.

Function
REQ-014 SHALL implement FSM states IDLE, READ, WRITE, FIN.
REQ-015 In IDLE with START=1, SHALL latch FUNCT3, CSR_NUM, RS1_NUM, RS1_DATA and RD_NUM, and go to READ; with START=0, SHALL stay in IDLE.
REQ-016 SHALL ignore START in every state other than IDLE; BUSY SHALL be 1 in every state except IDLE.
REQ-017 CSR_ADDR SHALL equal the latched CSR_NUM from READ through FIN.
REQ-018 In READ, SHALL capture CSR_RDATA into an old-value register.
REQ-019 Source operand: for funct3[2]=0, SHALL use the latched RS1_DATA; for funct3[2]=1, SHALL use {27'd0, zimm}.
REQ-020 New value: RW SHALL give src; RS SHALL give old|src; RC SHALL give old&~src; all operations are 32 bits wide.
REQ-021 Write suppression: RS, RC, RSI and RCI SHALL NOT write when RS1_NUM=0; RW and RWI SHALL always write.
REQ-022 From READ, SHALL go to WRITE if a write is required, else to FIN.
REQ-023 In WRITE, SHALL assert CSR_WE=1 for exactly one cycle with CSR_WDATA=new value, then go to FIN.
REQ-024 In FIN, SHALL pulse DONE=1 for one cycle and return to IDLE.
REQ-025 In FIN, SHALL drive RD_DATA=old value and RD_ADDR=latched RD_NUM, and SHALL assert RD_WE=1 only if RD_NUM!=0 and ILLEGAL=0.
REQ-026 Latency from START (cycle 0): DONE SHALL assert in cycle 3 with a write, or in cycle 2 without a write.
REQ-027 Illegal: funct3 000 or 100 SHALL be illegal; from READ, SHALL go to FIN with ILLEGAL=1, CSR_WE=0 and RD_WE=0.
REQ-028 ILLEGAL SHALL be valid only while DONE=1, and SHALL be 0 otherwise.
REQ-029 Outside WRITE, CSR_WE SHALL be 0 and CSR_WDATA SHALL be 0; outside FIN, RD_WE, DONE and RD_DATA SHALL be 0.
REQ-030 Back-to-back operation: START may assert in the cycle after DONE, and SHALL then be accepted.

Reset
REQ-031 RST=1 at a clock edge SHALL force IDLE from any state, including mid-operation.
REQ-032 On reset, all outputs SHALL be 0: CSR_ADDR, CSR_WDATA, CSR_WE, BUSY, DONE, ILLEGAL, RD_WE, RD_ADDR, RD_DATA.
REQ-033 A write interrupted by reset SHALL NOT issue CSR_WE in the cycle after the reset edge.
REQ-034 Reset SHALL clear all latched operands.

Configuration
REQ-035 With macro CORE_CSR_ACCESS_RO_CHECK_EN defined, a required write to CSR_NUM[11:10]=2'b11 SHALL be illegal (ILLEGAL=1, no CSR_WE, no RD_WE).
REQ-036 With CORE_CSR_ACCESS_RO_CHECK_EN defined, a suppressed write per REQ-021 to such an address SHALL remain legal.
REQ-037 Without CORE_CSR_ACCESS_RO_CHECK_EN, no read-only check SHALL exist, and such writes SHALL proceed normally.

Verification
REQ-038 Bench SHALL cover: CSRRW, CSR 0x305 holding 0x00000010, RS1_DATA=0x80000000, rd=5 -> CSR_WE cycle 2 with WDATA 0x80000000; DONE cycle 3; RD_WE=1, RD_ADDR=5, RD_DATA=0x00000010.
REQ-039 Bench SHALL cover: CSRRS, 0x300 holding 0x00000008, rs1=0, rd=3 -> no CSR_WE; DONE cycle 2; RD_DATA=0x00000008.
REQ-040 Bench SHALL cover: CSRRCI, 0x304 holding 0x00000888, zimm=8, rd=0 -> WDATA 0x00000880; RD_WE=0.
REQ-041 Bench SHALL cover: FUNCT3=100 -> DONE with ILLEGAL=1; CSR_WE never asserted.
REQ-042 Bench SHALL cover: with RO_CHECK_EN, CSRRW to 0xF14 -> ILLEGAL=1; CSRRS to 0xF14 with rs1=0 -> legal, RD_DATA=0.
REQ-043 Bench SHALL cover: RST=1 in the READ cycle of a CSRRW -> IDLE next cycle; CSR_WE stays 0; START during BUSY is ignored.
